pc_sequencer: RTL and testbench

//  Program-counter stage that consumes the jump target from the jump-address stage
//  (CJump). Holds the PC register, builds PC+4, and picks the next PC (sequential, branch or jump).

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, PC+STEP adder and next-PC select with req/ack fetch.
// Ports: Clk/Rst_n, Stall/Halt, Jump/JumpTgt, Branch/BranchTgt, ImemAck -> PC, PCPlus4, FetchReq, Halted, Wrapped.
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              JT_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              STEP     = 4
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Jump,
  input  logic [JT_W-1:0] JumpTgt,
  input  logic            Branch,
  input  logic [PC_W-1:0] BranchTgt,
  input  logic            ImemAck,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCPlus4,
  output logic            FetchReq,
  output logic            Halted,
  output logic            Wrapped
);

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_req_q, fetch_req_d;
  logic            halted_q, halted_d;
  logic            wrapped_q, wrapped_d;
  logic            pend_v_q, pend_v_d;
  logic [PC_W-1:0] pend_addr_q, pend_addr_d;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] br_addr;
  logic [PC_W-1:0] redir_addr;
  logic            redir;
  logic            advance;
  logic            unused_br_lsb;

  assign unused_br_lsb = ^BranchTgt[1:0];

  assign pc_plus4   = pc_q + STEP_V;
  assign jump_addr  = {pc_plus4[PC_W-1:JT_W], JumpTgt};
  assign br_addr    = {BranchTgt[PC_W-1:2], 2'b00};
  // jump beats branch, both when taken and when buffered
  assign redir      = Jump | Branch;
  assign redir_addr = Jump ? jump_addr : br_addr;
  assign advance    = (state_q == S_FETCH) & ~Halt
                    & ImemAck & ~Stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_req_d = fetch_req_q;
    halted_d    = halted_q;
    wrapped_d   = 1'b0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    unique case (state_q)
      S_IDLE: begin
        state_d     = S_FETCH;
        fetch_req_d = 1'b1;
      end
      S_FETCH: begin
        fetch_req_d = 1'b1;
        if (Halt) begin
          state_d     = S_HALT;
          fetch_req_d = 1'b0;
          halted_d    = 1'b1;
        end else if (advance) begin
          // any taken redirect supersedes a buffered one
          pend_v_d = 1'b0;
          if (Jump) begin
            pc_d = jump_addr;
          end else if (Branch) begin
            pc_d = br_addr;
          end else if (pend_v_q) begin
            pc_d = pend_addr_q;
          end else begin
            pc_d      = pc_plus4;
            wrapped_d = (pc_plus4 < pc_q);
          end
        end else if (redir) begin
          pend_v_d    = 1'b1;
          pend_addr_d = redir_addr;
        end
      end
      S_HALT: begin
        fetch_req_d = 1'b0;
        halted_d    = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        fetch_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      halted_q    <= 1'b0;
      wrapped_q   <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      halted_q    <= halted_d;
      wrapped_q   <= wrapped_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign PC       = pc_q;
  assign PCPlus4  = pc_plus4;
  assign FetchReq = fetch_req_q;
  assign Halted   = halted_q;
  assign Wrapped  = wrapped_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus short hand sequences.
// Drives inputs #1 after the rising edge and checks outputs there.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n, Stall, Halt, Jump, Branch, ImemAck;
  logic [5:0] JumpTgt;
  logic [7:0] BranchTgt;
  logic [7:0] PC, PCPlus4;
  logic       FetchReq, Halted, Wrapped;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Halt(Halt),
    .Jump(Jump), .JumpTgt(JumpTgt), .Branch(Branch),
    .BranchTgt(BranchTgt), .ImemAck(ImemAck), .PC(PC),
    .PCPlus4(PCPlus4), .FetchReq(FetchReq), .Halted(Halted),
    .Wrapped(Wrapped)
  );

  typedef struct {
    logic       r, s, h, j;
    logic [5:0] jt;
    logic       b;
    logic [7:0] bt;
    logic       a;
    logic [7:0] pc;
    logic       req, hl, wr;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    input logic r, s, h, j, input logic [5:0] jt,
    input logic b, input logic [7:0] bt, input logic a,
    input logic [7:0] pc, input logic req, hl, wr);
    vec_t t;
    t.r = r; t.s = s; t.h = h; t.j = j; t.jt = jt;
    t.b = b; t.bt = bt; t.a = a; t.pc = pc;
    t.req = req; t.hl = hl; t.wr = wr;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    Rst_n = t.r; Stall = t.s; Halt = t.h; Jump = t.j;
    JumpTgt = t.jt; Branch = t.b; BranchTgt = t.bt;
    ImemAck = t.a;
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, id, act, exp);
    end
  endtask

  task automatic step_chk(input vec_t t, input int id);
    logic [7:0] p4;
    drive(t);
    @(posedge Clk);
    #1;
    p4 = t.pc + 8'd4;
    chk("pc", id, PC, t.pc);
    chk("pcplus4", id, PCPlus4, p4);
    chk("fetchreq", id, {7'd0, FetchReq}, {7'd0, t.req});
    chk("halted", id, {7'd0, Halted}, {7'd0, t.hl});
    chk("wrapped", id, {7'd0, Wrapped}, {7'd0, t.wr});
  endtask

  initial begin
    drive(mk(0,0,0,0,6'h00,0,8'h00,0, 8'h00,0,0,0));
    // reset, dead cycle, sequential
    v.push_back(mk(0,0,0,0,6'h00,0,8'h00,0, 8'h00,0,0,0));
    v.push_back(mk(0,0,0,0,6'h00,0,8'h00,1, 8'h00,0,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,0, 8'h00,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h04,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h08,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h0C,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h10,1,0,0));
    // jumps, upper bits from PC+4
    v.push_back(mk(1,0,0,1,6'h2A,0,8'h00,1, 8'h2A,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,1,8'hC0,1, 8'hC0,1,0,0));
    v.push_back(mk(1,0,0,1,6'h2A,0,8'h00,1, 8'hEA,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,1,8'hC0,1, 8'hC0,1,0,0));
    v.push_back(mk(1,0,0,1,6'h3C,0,8'h00,1, 8'hFC,1,0,0));
    // wrap past max PC
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h00,1,0,1));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h04,1,0,0));
    // jump and branch together
    v.push_back(mk(1,0,0,1,6'h08,1,8'h80,1, 8'h08,1,0,0));
    // pending redirect, latest wins
    v.push_back(mk(1,0,0,0,6'h00,1,8'h20,1, 8'h20,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,1,8'h43,0, 8'h20,1,0,0));
    v.push_back(mk(1,0,0,1,6'h10,0,8'h00,0, 8'h20,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h10,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h14,1,0,0));
    // ack with stall
    v.push_back(mk(1,1,0,0,6'h00,0,8'h00,1, 8'h14,1,0,0));
    v.push_back(mk(1,1,0,0,6'h00,0,8'h00,1, 8'h14,1,0,0));
    v.push_back(mk(1,1,0,0,6'h00,0,8'h00,1, 8'h14,1,0,0));
    v.push_back(mk(1,1,0,1,6'h30,0,8'h00,1, 8'h14,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h30,1,0,0));
    // misaligned branch target
    v.push_back(mk(1,0,0,0,6'h00,1,8'h67,1, 8'h64,1,0,0));
    // halt is sticky and freezes PC
    v.push_back(mk(1,0,1,0,6'h00,0,8'h00,1, 8'h64,0,1,0));
    v.push_back(mk(1,0,0,1,6'h00,0,8'h00,1, 8'h64,0,1,0));
    v.push_back(mk(1,0,0,0,6'h00,1,8'h80,1, 8'h64,0,1,0));
    v.push_back(mk(0,0,0,0,6'h00,0,8'h00,1, 8'h00,0,0,0));
    // redirect in IDLE ignored
    v.push_back(mk(1,0,0,1,6'h3C,0,8'h00,1, 8'h00,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h04,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,0, 8'h04,1,0,0));
    v.push_back(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h08,1,0,0));

    @(posedge Clk);
    #1;
    foreach (v[i]) step_chk(v[i], i);

    // reset mid-fetch drops a buffered redirect
    step_chk(mk(1,0,0,1,6'h3C,0,8'h00,0, 8'h08,1,0,0), 100);
    step_chk(mk(0,0,0,0,6'h00,0,8'h00,1, 8'h00,0,0,0), 101);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h00,1,0,0), 102);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h04,1,0,0), 103);

    // halt beats stall, ack and jump in the same cycle
    step_chk(mk(1,1,1,1,6'h20,0,8'h00,1, 8'h04,0,1,0), 110);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h04,0,1,0), 111);

    // buffered branch consumed once, then sequential
    step_chk(mk(0,0,0,0,6'h00,0,8'h00,0, 8'h00,0,0,0), 120);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,0, 8'h00,1,0,0), 121);
    step_chk(mk(1,1,0,0,6'h00,1,8'hF9,1, 8'h00,1,0,0), 122);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'hF8,1,0,0), 123);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'hFC,1,0,0), 124);
    step_chk(mk(1,0,0,0,6'h00,0,8'h00,1, 8'h00,1,0,1), 125);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
